phi_lo_phase_cal_ctrl: RTL

// Run-time LO phase calibration sequencer for the MAC homodyne path. On start it sweeps the phi_lo shift register
// (ising_config::phi_lo_shift_amt_reg) over a window of candidate shift values. Each candidate is written over the

---
 rtl/phi_lo_phase_cal_ctrl_pkg.sv | 33 +++
 rtl/phi_lo_phase_cal_ctrl_accum.sv | 64 ++++++
 rtl/phi_lo_phase_cal_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/phi_lo_phase_cal_ctrl_pkg.sv
// ============================================================================
// Module      : phi_lo_phase_cal_ctrl_pkg
// Description : Shared definitions for the LO phase calibration sequencer.
//               Holds the config-space address of the phi_lo shift register,
//               the default calibration parameters and the sequencer states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package phi_lo_phase_cal_ctrl_pkg;

    // Config-space address of ising_config::phi_lo_shift_amt_reg
    localparam logic [15:0] c_phi_lo_shift_amt_reg = 16'h0027;

    // Calibration defaults shared with the config block
    localparam int c_phase_cal_avgs   = 1;
    localparam int c_phase_sweep_dist = 5;
    localparam int c_phase_sweep_step = 5;
    localparam int c_phase_cal_tol    = 10;

    typedef enum logic [2:0] {
        PC_IDLE   = 3'd0,
        PC_WRITE  = 3'd1,
        PC_SETTLE = 3'd2,
        PC_MEAS   = 3'd3,
        PC_EVAL   = 3'd4,
        PC_FAIL   = 3'd5,
        PC_DONE   = 3'd6
    } phase_cal_state_t;

endpackage

`default_nettype wire

// File: rtl/phi_lo_phase_cal_ctrl_accum.sv
// ============================================================================
// Module      : phase_cal_accum
// Description : Sample counter and signed accumulator for one calibration
//               candidate. Produces |mean| saturated to the largest positive
//               NUM_BITS value.
// Ports       : clk, rst     - clock, async active-high reset
//               clear        - zero counter and sum
//               en           - accept sample this cycle
//               sample       - signed ADC word
//               done         - this accepted sample is the CAL_AVGS-th
//               err          - |sum >>> log2(CAL_AVGS)|, saturated, unsigned
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_cal_accum #(
    parameter int NUM_BITS = 8,
    parameter int CAL_AVGS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                en,
    input  logic [NUM_BITS-1:0] sample,
    output logic                done,
    output logic [NUM_BITS-1:0] err
);

    localparam int c_SUM_W = NUM_BITS + 4;
    localparam int c_SHIFT = $clog2(CAL_AVGS);
    localparam logic [c_SUM_W-1:0] c_ERR_MAX = c_SUM_W'((2 ** (NUM_BITS - 1)) - 1);

    logic signed [c_SUM_W-1:0] r_sum;
    logic        [4:0]         r_cnt;
    logic signed [c_SUM_W-1:0] w_sample_ext;
    logic signed [c_SUM_W-1:0] w_mean;
    logic        [c_SUM_W-1:0] w_abs;

    assign w_sample_ext = {{4{sample[NUM_BITS-1]}}, sample};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
            r_cnt <= '0;
        end else if (clear) begin
            r_sum <= '0;
            r_cnt <= '0;
        end else if (en) begin
            r_sum <= r_sum + w_sample_ext;
            r_cnt <= r_cnt + 5'd1;
        end
    end

    assign done = en && (r_cnt == 5'(CAL_AVGS - 1));

    // The mean always fits NUM_BITS signed, so negation in the wide sum
    // cannot overflow; only -2**(NUM_BITS-1) needs clamping.
    assign w_mean = r_sum >>> c_SHIFT;
    assign w_abs  = w_mean[c_SUM_W-1] ? c_SUM_W'(-w_mean) : c_SUM_W'(w_mean);
    assign err    = (w_abs > c_ERR_MAX) ? c_ERR_MAX[NUM_BITS-1:0] : w_abs[NUM_BITS-1:0];

endmodule

`default_nettype wire

// File: rtl/phi_lo_phase_cal_ctrl.sv
// ============================================================================
// Module      : phi_lo_phase_cal_ctrl
// Description : LO phase calibration sequencer. Sweeps the phi_lo shift over
//               SWEEP_DIST candidates around a center, measures the mean ADC
//               word for each and stops once |mean| <= CAL_TOL. Each pass
//               re-centers on the best candidate and halves the step.
// Ports       : clk, rst                    - clock, async active-high reset
//               start, start_shift, abort   - control
//               cfg_wr_en/cfg_addr/cfg_data - shared config write port
//               meas_req/meas_valid/meas_data - ADC capture handshake
//               busy, done, cal_ok, cal_shift, best_err, pass_cnt - status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phi_lo_phase_cal_ctrl
    import phi_lo_phase_cal_ctrl_pkg::*;
#(
    parameter int NUM_BITS   = 8,
    parameter int SHIFT_W    = 8,
    parameter int CAL_AVGS   = c_phase_cal_avgs,
    parameter int SWEEP_DIST = c_phase_sweep_dist,
    parameter int SWEEP_STEP = c_phase_sweep_step,
    parameter int CAL_TOL    = c_phase_cal_tol,
    parameter int MAX_PASSES = 8,
    parameter int SETTLE_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SHIFT_W-1:0]  start_shift,
    input  logic                abort,
    output logic                cfg_wr_en,
    output logic [15:0]         cfg_addr,
    output logic [SHIFT_W-1:0]  cfg_data,
    output logic                meas_req,
    input  logic                meas_valid,
    input  logic [NUM_BITS-1:0] meas_data,
    output logic                busy,
    output logic                done,
    output logic                cal_ok,
    output logic [SHIFT_W-1:0]  cal_shift,
    output logic [NUM_BITS-1:0] best_err,
    output logic [3:0]          pass_cnt
);

    localparam logic [NUM_BITS-1:0] c_ERR_MAX     = NUM_BITS'((2 ** (NUM_BITS - 1)) - 1);
    localparam int                  c_HALF        = SWEEP_DIST / 2;
    localparam bit                  c_SKIP_SETTLE = (SETTLE_CYC == 0);

    phase_cal_state_t r_state, w_next;

    logic [SHIFT_W-1:0]  r_center, r_step, r_best_shift, r_cal_shift;
    logic [NUM_BITS-1:0] r_best_err;
    logic [3:0]          r_k, r_pass_cnt;
    logic [7:0]          r_settle;
    logic                r_cal_ok, r_done;

    logic                w_busy, w_start_ok, w_abort_busy, w_acc_en, w_acc_done;
    logic                w_is_better, w_hit, w_last_cand, w_last_pass;
    logic [NUM_BITS-1:0] w_err;
    logic [SHIFT_W+3:0]  w_lo_off, w_k_off;
    logic [SHIFT_W-1:0]  w_shift, w_best_shift_nx, w_step_nx;

    // Candidate shift; wraps modulo 2**SHIFT_W through natural truncation
    assign w_lo_off = (SHIFT_W + 4)'(c_HALF) * {4'd0, r_step};
    assign w_k_off  = {{SHIFT_W{1'b0}}, r_k} * {4'd0, r_step};
    assign w_shift  = r_center - w_lo_off[SHIFT_W-1:0] + w_k_off[SHIFT_W-1:0];

    assign w_busy       = (r_state != PC_IDLE) && (r_state != PC_DONE);
    assign w_start_ok   = start && !abort && (r_state == PC_IDLE);
    assign w_abort_busy = abort && w_busy;
    // Samples count only while requesting; abort masks a coincident valid
    assign w_acc_en     = meas_valid && !abort && (r_state == PC_MEAS);

    phase_cal_accum #(
        .NUM_BITS (NUM_BITS),
        .CAL_AVGS (CAL_AVGS)
    ) u_accum (
        .clk    (clk),
        .rst    (rst),
        .clear  (r_state == PC_WRITE),
        .en     (w_acc_en),
        .sample (meas_data),
        .done   (w_acc_done),
        .err    (w_err)
    );

    assign w_is_better     = (w_err < r_best_err);
    assign w_hit           = (w_err <= NUM_BITS'(CAL_TOL));
    assign w_last_cand     = (r_k == 4'(SWEEP_DIST - 1));
    assign w_last_pass     = (r_pass_cnt == 4'(MAX_PASSES));
    // Next pass centers on the best including the candidate evaluated now
    assign w_best_shift_nx = w_is_better ? w_shift : r_best_shift;
    assign w_step_nx       = ((r_step >> 1) == '0) ? SHIFT_W'(1) : (r_step >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= PC_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        cfg_wr_en = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        meas_req  = 1'b0;
        case (r_state)
            PC_IDLE:   if (start) w_next = PC_WRITE;
            PC_WRITE: begin
                cfg_wr_en = 1'b1;
                cfg_addr  = c_phi_lo_shift_amt_reg;
                cfg_data  = w_shift;
                w_next    = c_SKIP_SETTLE ? PC_MEAS : PC_SETTLE;
            end
            PC_SETTLE: if (r_settle == 8'd1) w_next = PC_MEAS;
            PC_MEAS: begin
                meas_req = 1'b1;
                if (w_acc_done) w_next = PC_EVAL;
            end
            PC_EVAL: begin
                if (w_hit)             w_next = PC_DONE;
                else if (!w_last_cand) w_next = PC_WRITE;
                else if (w_last_pass)  w_next = PC_FAIL;
                else                   w_next = PC_WRITE;
            end
            PC_FAIL: begin
                cfg_wr_en = 1'b1;
                cfg_addr  = c_phi_lo_shift_amt_reg;
                cfg_data  = r_best_shift;
                w_next    = PC_DONE;
            end
            PC_DONE:   w_next = PC_IDLE;
            default:   w_next = PC_IDLE;
        endcase
        if (abort) w_next = PC_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_center     <= '0;
            r_step       <= SHIFT_W'(SWEEP_STEP);
            r_best_shift <= '0;
            r_cal_shift  <= '0;
            r_best_err   <= '0;
            r_k          <= '0;
            r_pass_cnt   <= '0;
            r_settle     <= '0;
            r_cal_ok     <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_abort_busy || (w_next == PC_DONE);
            if (w_start_ok) begin
                r_center     <= start_shift;
                r_step       <= SHIFT_W'(SWEEP_STEP);
                r_best_shift <= start_shift;
                r_best_err   <= c_ERR_MAX;
                r_pass_cnt   <= 4'd1;
                r_k          <= '0;
                r_cal_ok     <= 1'b0;
            end
            if (w_abort_busy) r_cal_ok <= 1'b0;
            if (r_state == PC_WRITE)       r_settle <= 8'(SETTLE_CYC);
            else if (r_state == PC_SETTLE) r_settle <= r_settle - 8'd1;
            if ((r_state == PC_EVAL) && !abort) begin
                if (w_is_better) begin
                    r_best_err   <= w_err;
                    r_best_shift <= w_shift;
                end
                if (w_hit) begin
                    r_cal_ok    <= 1'b1;
                    r_cal_shift <= w_shift;
                end else if (!w_last_cand) begin
                    r_k <= r_k + 4'd1;
                end else if (!w_last_pass) begin
                    r_center   <= w_best_shift_nx;
                    r_step     <= w_step_nx;
                    r_k        <= '0;
                    r_pass_cnt <= r_pass_cnt + 4'd1;
                end
            end
            if ((r_state == PC_FAIL) && !abort) begin
                r_cal_shift <= r_best_shift;
                r_cal_ok    <= 1'b0;
            end
        end
    end

    assign busy      = w_busy;
    assign done      = r_done;
    assign cal_ok    = r_cal_ok;
    assign cal_shift = r_cal_shift;
    assign best_err  = r_best_err;
    assign pass_cnt  = r_pass_cnt;

endmodule

`default_nettype wire
